// File: rtl/ristretto_regfile_sb.sv
// Multi-write-port integer register file with a pending-write scoreboard for issue stalls.
// Register 0 reads as zero; same-cycle write-backs can optionally be forwarded to the read ports.
module ristretto_regfile_sb #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumRegs    = 32,
    parameter int unsigned NumWrPorts = 2,
    parameter int unsigned BypassEn   = 1,
    localparam int unsigned AddrWidth = $clog2(NumRegs)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [AddrWidth-1:0]             rf_rs1_addr_i,
    input  logic [AddrWidth-1:0]             rf_rs2_addr_i,
    output logic [DataWidth-1:0]             rf_rs1_data_o,
    output logic [DataWidth-1:0]             rf_rs2_data_o,
    output logic                             rf_rs1_busy_o,
    output logic                             rf_rs2_busy_o,
    input  logic [NumWrPorts-1:0]            rf_wr_en_i,
    input  logic [NumWrPorts*AddrWidth-1:0]  rf_wr_addr_i,
    input  logic [NumWrPorts*DataWidth-1:0]  rf_wr_data_i,
    input  logic                             rf_rsv_en_i,
    input  logic [AddrWidth-1:0]             rf_rsv_addr_i,
    output logic                             rf_rsv_busy_o
);

    logic [NumRegs-1:0][DataWidth-1:0] regs_q, regs_d;
    logic [NumRegs-1:0]                pend_q, pend_d;

    // Per-register view of this cycle's write-backs; later ports overwrite earlier ones.
    logic [NumRegs-1:0]                wr_hit;
    logic [NumRegs-1:0][DataWidth-1:0] wr_val;

    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int unsigned p = 0; p < NumWrPorts; p++) begin
            if (rf_wr_en_i[p]) begin
                wr_hit[rf_wr_addr_i[p*AddrWidth +: AddrWidth]] = 1'b1;
                wr_val[rf_wr_addr_i[p*AddrWidth +: AddrWidth]] =
                    rf_wr_data_i[p*DataWidth +: DataWidth];
            end
        end
        wr_hit[0] = 1'b0;
        wr_val[0] = '0;
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int unsigned r = 1; r < NumRegs; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_val[r];
                pend_d[r] = 1'b0;
            end
        end
        // Applied after the clears so a same-cycle reservation keeps the register pending.
        if (rf_rsv_en_i && (rf_rsv_addr_i != '0)) begin
            pend_d[rf_rsv_addr_i] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rf_rs1_data_o = regs_q[rf_rs1_addr_i];
        rf_rs1_busy_o = pend_q[rf_rs1_addr_i];
        if ((BypassEn != 0) && wr_hit[rf_rs1_addr_i]) begin
            rf_rs1_data_o = wr_val[rf_rs1_addr_i];
            rf_rs1_busy_o = 1'b0;
        end
        if (rf_rs1_addr_i == '0) begin
            rf_rs1_data_o = '0;
            rf_rs1_busy_o = 1'b0;
        end
    end

    always_comb begin
        rf_rs2_data_o = regs_q[rf_rs2_addr_i];
        rf_rs2_busy_o = pend_q[rf_rs2_addr_i];
        if ((BypassEn != 0) && wr_hit[rf_rs2_addr_i]) begin
            rf_rs2_data_o = wr_val[rf_rs2_addr_i];
            rf_rs2_busy_o = 1'b0;
        end
        if (rf_rs2_addr_i == '0) begin
            rf_rs2_data_o = '0;
            rf_rs2_busy_o = 1'b0;
        end
    end

    always_comb begin
        rf_rsv_busy_o = pend_q[rf_rsv_addr_i];
        if ((BypassEn != 0) && wr_hit[rf_rsv_addr_i]) begin
            rf_rsv_busy_o = 1'b0;
        end
        if (rf_rsv_addr_i == '0) begin
            rf_rsv_busy_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ristretto_regfile_sb.sv
// Bench for ristretto_regfile_sb: one instance without and one with bypass, driven identically.
module tb_ristretto_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int NP = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]    rs1, rs2, ra;
    logic             rsv;
    logic [NP-1:0]    wen;
    logic [NP*AW-1:0] wa;
    logic [NP*DW-1:0] wd;

    logic [1:0][DW-1:0] d1, d2;
    logic [1:0]         b1, b2, rb;

    ristretto_regfile_sb #(.DataWidth(DW), .NumRegs(NR), .NumWrPorts(NP), .BypassEn(0)) u_nobyp (
        .clk_i(clk), .rst_i(rst),
        .rf_rs1_addr_i(rs1), .rf_rs2_addr_i(rs2),
        .rf_rs1_data_o(d1[0]), .rf_rs2_data_o(d2[0]),
        .rf_rs1_busy_o(b1[0]), .rf_rs2_busy_o(b2[0]),
        .rf_wr_en_i(wen), .rf_wr_addr_i(wa), .rf_wr_data_i(wd),
        .rf_rsv_en_i(rsv), .rf_rsv_addr_i(ra), .rf_rsv_busy_o(rb[0])
    );

    ristretto_regfile_sb #(.DataWidth(DW), .NumRegs(NR), .NumWrPorts(NP), .BypassEn(1)) u_byp (
        .clk_i(clk), .rst_i(rst),
        .rf_rs1_addr_i(rs1), .rf_rs2_addr_i(rs2),
        .rf_rs1_data_o(d1[1]), .rf_rs2_data_o(d2[1]),
        .rf_rs1_busy_o(b1[1]), .rf_rs2_busy_o(b2[1]),
        .rf_wr_en_i(wen), .rf_wr_addr_i(wa), .rf_wr_data_i(wd),
        .rf_rsv_en_i(rsv), .rf_rsv_addr_i(ra), .rf_rsv_busy_o(rb[1])
    );

    typedef struct {
        logic [DW-1:0] d1;
        logic          b1;
        logic [DW-1:0] d2;
        logic          b2;
        logic          rb;
    } obs_t;

    typedef struct {
        logic             rst;
        logic [NP-1:0]    wen;
        logic [NP*AW-1:0] wa;
        logic [NP*DW-1:0] wd;
        logic             rsv;
        logic [AW-1:0]    ra, rs1, rs2;
        obs_t             e0, e1;
    } vec_t;

    vec_t tbl[$];
    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] m_reg [NR];
    logic          m_pend[NR];

    function automatic obs_t ob(logic [DW-1:0] x1, logic y1, logic [DW-1:0] x2, logic y2,
                                logic r);
        obs_t o;
        o.d1 = x1; o.b1 = y1; o.d2 = x2; o.b2 = y2; o.rb = r;
        return o;
    endfunction

    function automatic logic [NP*AW-1:0] w3a(logic [AW-1:0] a2, logic [AW-1:0] a1,
                                             logic [AW-1:0] a0);
        return {a2, a1, a0};
    endfunction

    function automatic logic [NP*DW-1:0] w3d(logic [DW-1:0] x2, logic [DW-1:0] x1,
                                             logic [DW-1:0] x0);
        return {x2, x1, x0};
    endfunction

    task automatic add(logic r, logic [NP-1:0] we, logic [NP*AW-1:0] a, logic [NP*DW-1:0] d,
                       logic rv, logic [AW-1:0] rva, logic [AW-1:0] s1, logic [AW-1:0] s2,
                       obs_t e0, obs_t e1);
        vec_t v;
        v.rst = r; v.wen = we; v.wa = a; v.wd = d; v.rsv = rv; v.ra = rva;
        v.rs1 = s1; v.rs2 = s2; v.e0 = e0; v.e1 = e1;
        tbl.push_back(v);
    endtask

    task automatic cmp(string nm, int inst, logic [DW-1:0] got, logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, inst, $time, got, want);
        end
    endtask

    // Expected values are queued at drive time and retired mid-cycle against the DUT.
    task automatic run_cycle(string nm, obs_t e0, obs_t e1);
        obs_t x;
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        #3;
        x = exp_q0.pop_front();
        cmp({nm, ".rs1_data"}, 0, d1[0], x.d1);
        cmp({nm, ".rs1_busy"}, 0, DW'(b1[0]), DW'(x.b1));
        cmp({nm, ".rs2_data"}, 0, d2[0], x.d2);
        cmp({nm, ".rs2_busy"}, 0, DW'(b2[0]), DW'(x.b2));
        cmp({nm, ".rsv_busy"}, 0, DW'(rb[0]), DW'(x.rb));
        x = exp_q1.pop_front();
        cmp({nm, ".rs1_data"}, 1, d1[1], x.d1);
        cmp({nm, ".rs1_busy"}, 1, DW'(b1[1]), DW'(x.b1));
        cmp({nm, ".rs2_data"}, 1, d2[1], x.d2);
        cmp({nm, ".rs2_busy"}, 1, DW'(b2[1]), DW'(x.b2));
        cmp({nm, ".rsv_busy"}, 1, DW'(rb[1]), DW'(x.rb));
        @(posedge clk);
        #1;
    endtask

    function automatic void model_read(logic [AW-1:0] a, bit byp, output logic [DW-1:0] d,
                                       output logic b);
        bit            hit = 0;
        logic [DW-1:0] hd  = '0;
        for (int p = 0; p < NP; p++) begin
            if (wen[p] && wa[p*AW +: AW] == a) begin
                hit = 1;
                hd  = wd[p*DW +: DW];
            end
        end
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (byp && hit) begin
            d = hd; b = 1'b0;
        end else begin
            d = m_reg[a]; b = m_pend[a];
        end
    endfunction

    function automatic obs_t model_obs(bit byp);
        obs_t          o;
        logic [DW-1:0] dummy;
        model_read(rs1, byp, o.d1, o.b1);
        model_read(rs2, byp, o.d2, o.b2);
        model_read(ra, byp, dummy, o.rb);
        return o;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_reg[r] = '0; m_pend[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (wen[p] && wa[p*AW +: AW] != 0) begin
                    m_reg[wa[p*AW +: AW]]  = wd[p*DW +: DW];
                    m_pend[wa[p*AW +: AW]] = 1'b0;
                end
            end
            if (rsv && ra != 0) m_pend[ra] = 1'b1;
        end
    endtask

    initial begin
        obs_t z;
        obs_t e;
        z = ob(0, 0, 0, 0, 0);

        for (int a = 0; a < NR; a++)
            add(0, 3'b000, '0, '0, 0, AW'(a), AW'(a), AW'(15 - a), z, z);
        add(0, 3'b001, w3a(0, 0, 0), w3d(0, 0, 32'hDEADBEEF), 1, 0, 0, 0, z, z);
        add(0, 3'b000, '0, '0, 0, 0, 0, 0, z, z);
        add(0, 3'b011, w3a(0, 5, 5), w3d(0, 32'h22, 32'h11), 0, 5, 5, 5,
            z, ob(32'h22, 0, 32'h22, 0, 0));
        add(0, 3'b000, '0, '0, 0, 5, 5, 5, ob(32'h22, 0, 32'h22, 0, 0), ob(32'h22, 0, 32'h22, 0, 0));
        add(0, 3'b000, '0, '0, 1, 7, 7, 7, z, z);
        add(0, 3'b000, '0, '0, 0, 7, 7, 7, ob(0, 1, 0, 1, 1), ob(0, 1, 0, 1, 1));
        add(0, 3'b000, '0, '0, 0, 7, 7, 7, ob(0, 1, 0, 1, 1), ob(0, 1, 0, 1, 1));
        add(0, 3'b010, w3a(0, 7, 0), w3d(0, 32'hABCD, 0), 0, 7, 7, 7,
            ob(0, 1, 0, 1, 1), ob(32'hABCD, 0, 32'hABCD, 0, 0));
        add(0, 3'b000, '0, '0, 0, 7, 7, 7,
            ob(32'hABCD, 0, 32'hABCD, 0, 0), ob(32'hABCD, 0, 32'hABCD, 0, 0));
        add(0, 3'b001, w3a(0, 0, 9), w3d(0, 0, 5), 1, 9, 9, 9, z, ob(5, 0, 5, 0, 0));
        add(0, 3'b000, '0, '0, 1, 9, 9, 9, ob(5, 1, 5, 1, 1), ob(5, 1, 5, 1, 1));
        add(0, 3'b000, '0, '0, 1, 3, 3, 3, z, z);
        add(0, 3'b100, w3a(10, 0, 0), w3d(32'h77, 0, 0), 1, 4, 3, 10,
            ob(0, 1, 0, 0, 0), ob(0, 1, 32'h77, 0, 0));
        add(0, 3'b000, '0, '0, 0, 3, 4, 10, ob(0, 1, 32'h77, 0, 1), ob(0, 1, 32'h77, 0, 1));
        add(1, 3'b001, w3a(0, 0, 13), w3d(0, 0, 32'h99), 1, 14, 4, 10,
            ob(0, 1, 32'h77, 0, 0), ob(0, 1, 32'h77, 0, 0));
        add(0, 3'b000, '0, '0, 0, 3, 9, 10, z, z);
        add(0, 3'b000, '0, '0, 0, 14, 13, 7, z, z);
        add(0, 3'b111, w3a(12, 12, 12), w3d(3, 2, 1), 0, 12, 12, 0, z, ob(3, 0, 0, 0, 0));
        add(0, 3'b000, '0, '0, 0, 12, 12, 5, ob(3, 0, 0, 0, 0), ob(3, 0, 0, 0, 0));

        rs1 = '0; rs2 = '0; ra = '0; rsv = 1'b0; wen = '0; wa = '0; wd = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; wen = tbl[i].wen; wa = tbl[i].wa; wd = tbl[i].wd;
            rsv = tbl[i].rsv; ra = tbl[i].ra; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            run_cycle($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1);
        end

        rst = 1'b1; wen = '0; rsv = 1'b0;
        @(posedge clk);
        #1;
        model_edge();
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                wen[p]          = ($urandom_range(0, 2) == 0);
                wa[p*AW +: AW]  = AW'($urandom_range(0, NR - 1));
                wd[p*DW +: DW]  = $urandom;
            end
            rsv = ($urandom_range(0, 2) == 0);
            ra  = AW'($urandom_range(0, NR - 1));
            rs1 = AW'($urandom_range(0, NR - 1));
            rs2 = AW'($urandom_range(0, NR - 1));
            e   = model_obs(1'b1);
            run_cycle("rnd", model_obs(1'b0), e);
            model_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ristretto_regfile_sb.md
# ristretto_regfile_sb

Parametrised integer register file with N write ports, optional write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-write-port register file in the core, so multi-cycle units (load/store, mul/div) can write back alongside the ALU. Issue logic reserves the destination at issue and stalls on the busy flags of the source registers.

## Interface
Parameters:
- DataWidth, 32, register width in bits.
- NumRegs, 32, number of architectural registers (power of two, ≥2); AddrWidth = $clog2(NumRegs).
- NumWrPorts, 2, number of write-back ports (1..4).
- BypassEn, 1, when 1, same-cycle write data and scoreboard clears are forwarded to read outputs.

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rf_rs1_addr_i  in  AddrWidth  read port 1 address.
- rf_rs2_addr_i  in  AddrWidth  read port 2 address.
- rf_rs1_data_o  out  DataWidth  read port 1 data (combinational).
- rf_rs2_data_o  out  DataWidth  read port 2 data (combinational).
- rf_rs1_busy_o  out  1  rs1 has a pending write.
- rf_rs2_busy_o  out  1  rs2 has a pending write.
- rf_wr_en_i  in  NumWrPorts  per-port write enable.
- rf_wr_addr_i  in  NumWrPorts×AddrWidth  per-port destination address (packed, port p at [p*AddrWidth +: AddrWidth]).
- rf_wr_data_i  in  NumWrPorts×DataWidth  per-port write data (packed likewise).
- rf_rsv_en_i  in  1  reserve (mark pending) the register at rf_rsv_addr_i.
- rf_rsv_addr_i  in  AddrWidth  register to reserve.
- rf_rsv_busy_o  out  1  register at rf_rsv_addr_i is already pending (WAW indicator, combinational).

## Operation
- Storage: NumRegs × DataWidth data array plus a NumRegs-bit pending vector.
- Register 0 is hardwired to zero. Writes and reservations to address 0 are ignored. Reads of address 0 return 0 with busy 0, also when bypassed.
- Write: each port with en=1 and addr≠0 writes its data on the clock edge. If several ports target the same address in one cycle, the highest-indexed port wins.
- Scoreboard clear: any enabled write port with addr≠0 clears pending[addr] on the same edge.
- Scoreboard set: rf_rsv_en_i with addr≠0 sets pending[addr] on the edge. If a reservation and a write-back hit the same address in one cycle, the reservation wins: data is written and pending stays 1.
- Reservation of an already-pending register is legal. Pending stays 1 and rf_rsv_busy_o=1 flags it; the block does not track write counts.
- Read, BypassEn=0: data = array[addr], busy = pending[addr].
- Read, BypassEn=1: if any enabled write port matches addr≠0 this cycle, data = that port's data (highest index wins) and busy = 0. Otherwise read as for BypassEn=0. A reservation issued this cycle is never bypassed.
- rf_rsv_busy_o = pending[rf_rsv_addr_i] (0 for address 0). It uses the same bypass rule as the read ports.
- Reset (rst_i=1 at an edge): all registers 0, all pending bits 0. Writes and reservations in that cycle are discarded. Reset mid-operation drops all outstanding reservations.

## Timing
- Read outputs are combinational from addresses and state: zero latency.
- Write data is visible in the array on the cycle after the write edge. With BypassEn=1 it is also visible in the same cycle.
- A reservation is visible on busy outputs the cycle after rf_rsv_en_i.
- A write-back clears busy the cycle after the edge. With BypassEn=1 busy is already 0 in the write-back cycle.
- After reset is released: every read returns 0 and every busy output is 0.

## Test plan
- Reset, then read all addresses on both ports -> data 0 and busy 0 everywhere; write 0xDEADBEEF to x0 -> x0 still reads 0.
- Ports 0 and 1 both write x5 (0x11, 0x22) in one cycle -> next cycle x5 = 0x22. With BypassEn=1, rs1=x5 reads 0x22 in the write cycle itself.
- Reserve x7, then two idle cycles -> rs2_busy=1; port 1 writes x7=0xABCD -> busy 0 the same cycle (BypassEn=1) or the next cycle (BypassEn=0), data 0xABCD.
- Same cycle: reserve x9 and port 0 writes x9=0x5 -> next cycle x9 = 0x5 and busy = 1; rf_rsv_busy_o=1 when reserving x9 again.
- Reserve x3 and x4, write x10=0x77, then assert rst_i for one cycle -> all busy 0 and x10 reads 0.
- Randomised multi-port write/reserve traffic against a reference model with NumRegs=16, NumWrPorts=3, BypassEn=0 and 1 -> exact data and busy match every cycle.
